// File: rtl/key_input_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_map_pkg
// Brief    : I/O region map, read-mux select codes and KEY word field layout.
// Revision : 1.0
// ============================================================================
package io_map_pkg;

    localparam logic [3:0] IO_REGION = 4'hF;

    localparam logic [7:0] OFF_HEX  = 8'h00;
    localparam logic [7:0] OFF_LEDR = 8'h04;
    localparam logic [7:0] OFF_LEDG = 8'h08;
    localparam logic [7:0] OFF_KEY  = 8'h10;
    localparam logic [7:0] OFF_SW   = 8'h14;

    localparam logic [1:0] SEL_MEM = 2'd0;
    localparam logic [1:0] SEL_SW  = 2'd1;
    localparam logic [1:0] SEL_KEY = 2'd2;

    localparam int PRESSED_LSB = 0;
    localparam int EVENT_LSB   = 4;

    typedef enum logic [0:0] {
        DEB_HOLD  = 1'b0,
        DEB_COUNT = 1'b1
    } debState_t;

endpackage
`default_nettype wire

// File: rtl/key_input_port_if.sv
`default_nettype none
// ============================================================================
// Module   : key_input_port_if
// Brief    : Load-side read bus between the I/O decoder and the KEY port.
// Revision : 1.0
// ============================================================================
interface key_input_port_if;

    logic        keyEn;
    logic [31:0] key_rdata;
    logic        key_irq;

    modport master (output keyEn, input key_rdata, input key_irq);
    modport slave  (input keyEn, output key_rdata, output key_irq);

endinterface
`default_nettype wire

// File: rtl/key_input_port_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : key_debouncer
// Brief    : One pushbutton: 2-flop synchronizer, inversion and debouncer.
//            KEY_DEBOUNCE_EN selects the counting debouncer; otherwise the
//            stable bit simply follows the synchronized level.
// Revision : 1.0
// ============================================================================
module key_debouncer
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_keyRaw,
    output logic      o_stable,
    output logic      o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_stable;
    logic w_pressed;
    logic w_stableNext;

    // Sync flops reset to the released (high) level of the active-low pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_keyRaw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

`ifdef KEY_DEBOUNCE_EN
    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    debState_t          r_state;
    debState_t          w_stateNext;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cntNext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= DEB_HOLD;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_stable <= w_stableNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_stableNext = r_stable;
        case (r_state)
            DEB_HOLD, DEB_COUNT: begin
                if (w_pressed == r_stable) begin
                    w_stateNext = DEB_HOLD;
                    w_cntNext   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_stableNext = ~r_stable;
                    w_stateNext  = DEB_HOLD;
                    w_cntNext    = '0;
                end else begin
                    w_stateNext = DEB_COUNT;
                    w_cntNext   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_stateNext = DEB_HOLD;
                w_cntNext   = '0;
            end
        endcase
    end
`else
    assign w_stableNext = w_pressed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= 1'b0;
        end else begin
            r_stable <= w_stableNext;
        end
    end
`endif

    // Rise is taken from the next-state value so the event lands on the same
    // edge as the stable bit.
    assign o_stable = r_stable;
    assign o_rise   = w_stableNext & ~r_stable;

endmodule
`default_nettype wire

// File: rtl/key_input_port.sv
`default_nettype none
// ============================================================================
// Module   : key_input_port
// Brief    : Memory-mapped KEY peripheral: debounced levels, sticky
//            clear-on-read press events and the 32-bit read word.
//            Debounce counters enabled by KEY_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
module key_input_port
    import io_map_pkg::*;
#(
    parameter int KEY_W           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic [KEY_W-1:0] key_in,
    key_input_port_if.slave       bus
);

    logic [KEY_W-1:0] w_stable;
    logic [KEY_W-1:0] w_rise;
    logic [KEY_W-1:0] r_events;

    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_keyRaw (key_in[gi]),
            .o_stable (w_stable[gi]),
            .o_rise   (w_rise[gi])
        );
    end

    // A read clears everything except an event arriving on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_events <= '0;
        end else if (bus.keyEn) begin
            r_events <= w_rise;
        end else begin
            r_events <= r_events | w_rise;
        end
    end

    assign bus.key_rdata = (32'(r_events) << EVENT_LSB) | (32'(w_stable) << PRESSED_LSB);
    assign bus.key_irq   = |r_events;

endmodule
`default_nettype wire
